attack_responder: RTL and testbench
===================================

Name: attack_responder

Overview:
- Executes the attack and check phases requested by the game-flow FSM and returns that FSM's status inputs: end_attack_p1, end_attack_p2, timeout, turno and gameover.
- Per turn: runs the turn timer, accepts the player's coordinate or generates a random one, queries the ship map and records the shot.
- Updates the turn and game-over status before the FSM issues its check.

Parameters:
- N, 5, board dimension (N x N cells, N <= 8).
- COORD_W, 3, width of row/col coordinates.
- SHIP_CELLS, 6, ship cells per board; hits reaching this value end the game.
- TIMEOUT_CYCLES, 750000000, cycles per turn before timeout (15 s at 50 MHz).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- en_attack_p1  in  1  FSM: player 1 attack phase.
- en_attack_p2  in  1  FSM: player 2 attack phase.
- en_attack_random  in  1  FSM: random attack request, used for timeout or the CPU player.
- en_check  in  1  FSM: check phase.
- select  in  1  synchronized, debounced single-cycle button pulse.
- row_in  in  COORD_W  player-chosen row.
- col_in  in  COORD_W  player-chosen column.
- board_rsp  in  1  ship-map read data; 1 = ship. Valid one cycle after board_req.
- board_req  out  1  ship-map read strobe.
- board_sel  out  1  board queried: 0 = player 1's board, 1 = player 2's board.
- board_row  out  COORD_W  query row.
- board_col  out  COORD_W  query column.
- end_attack_p1  out  1  player 1 attack complete (level).
- end_attack_p2  out  1  player 2 attack complete (level).
- timeout  out  1  turn timer expired (level).
- turno  out  1  next shooter: 1 = player 1, 0 = player 2.
- gameover  out  1  game finished (sticky).
- winner  out  1  0 = player 1, 1 = player 2; valid when gameover = 1.
- hit  out  1  result of the last shot.
- hit_valid  out  1  one-cycle pulse when hit updates.

Behaviour:
- Reset values: all outputs 0 except turno = 1. Shot maps, hit counters and timer are cleared; LFSR loads 16'hACE1; state = IDLE. Reset mid-operation aborts any pending query.
- Attack phase: active = en_attack_p1 | en_attack_p2. The FSM alternates these enables with its wait state every other cycle, so the responder keeps a sticky attack_busy flag. The flag sets on the first enable and clears on en_check or en_attack_random.
- Shooter: player 1 when the sticky phase began with en_attack_p1, otherwise player 2. Target board = the other player's board.
- Timer: counts while attack_busy = 1 and state = AIM. On reaching TIMEOUT_CYCLES-1, timeout = 1 and stays 1 until en_attack_random is seen. The timer resets on en_check.
- States:
  - IDLE → AIM when attack_busy = 1.
  - IDLE → RAND on en_attack_random.
  - AIM: on select, if row_in < N, col_in < N and the cell is not yet in the shooter's shot map, go to LOOKUP. Otherwise ignore the select and stay in AIM.
  - RAND: candidate row = lfsr[2:0], col = lfsr[5:3]. Accept when in range and not yet shot; otherwise retry next cycle (LFSR free-runs one step per cycle). Termination is guaranteed because gameover occurs before the board fills.
  - RAND shooter = turno at entry. This covers both timeout and the CPU player.
  - LOOKUP: one-cycle board_req with board_sel/row/col driven → WAIT.
  - WAIT: sample board_rsp, set the shot-map bit, drive hit and hit_valid.
    - If hit, increment the shooter's counter; when it reaches SHIP_CELLS set gameover and winner.
    - Toggle turno in the same cycle unless gameover.
    - Manual attack: set end_attack_p1 or end_attack_p2 → DONE.
    - Random attack: go directly to DONE.
  - DONE: hold outputs; on en_check clear end_attack_* and go to IDLE.
- turno and gameover are therefore stable before en_check is issued; the FSM samples them in the check cycle.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11.
- Simultaneous events: a select arriving in the same cycle as timeout expiry is ignored; timeout wins.
- After gameover, all enables are ignored except reset.
- Widths: hit counters are $clog2(SHIP_CELLS+1) bits; the timer is $clog2(TIMEOUT_CYCLES) bits. Shot maps are two N*N-bit registers indexed row*N+col.

Decomposition:
- Package game_pkg: N, COORD_W, SHIP_CELLS, the responder state enum (IDLE, AIM, RAND, LOOKUP, WAIT, DONE) and the player encoding constants.
- Sub-module lfsr16: enable, seed, 16-bit output.

Test Plan:
- Reset → turno = 1, gameover = 0, end_attack_* = 0, timeout = 0, LFSR = 16'hACE1.
- Sequence:
  - Stimulus: en_attack_p1 toggling every other cycle, then select with row = 2, col = 3 and board_rsp = 1.
  - Response: one board_req with board_sel = 1, row = 2, col = 3; hit = 1; end_attack_p1 = 1; turno = 0.
  - After en_check: end_attack_p1 = 0.
- Repeat select at (2,3) in a later player 1 turn → no board_req and no end_attack_p1; then (0,0) → accepted. Also select at (6,1) with N = 5 → ignored.
- Sequence:
  - Stimulus: TIMEOUT_CYCLES = 20, en_attack_p2 with no select.
  - Response: timeout = 1 at cycle 20, held until en_attack_random. The random attack then queries an in-range, unshot cell on board 0 and turno = 1.
- Six player 1 hits on board_rsp = 1 → gameover = 1 and winner = 0 on the sixth hit's WAIT cycle; turno does not toggle; later enables are ignored.
- rst asserted while in WAIT → all outputs return to reset values immediately; no shot-map bit is set.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the battleship attack datapath.
//   N, COORD_W, SHIP_CELLS : board geometry and win threshold
//   resp_state_e           : attack responder state encoding
//   PLAYER1 / PLAYER2      : player encoding (also used for winner)
//   coord_ok / cell_idx    : coordinate range check and shot-map index
package game_pkg;

  localparam int N          = 5;
  localparam int COORD_W    = 3;
  localparam int SHIP_CELLS = 6;
  localparam int CELLS      = N * N;
  localparam int IDX_W      = $clog2(CELLS);

  localparam logic PLAYER1 = 1'b0;
  localparam logic PLAYER2 = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    AIM    = 3'd1,
    RAND   = 3'd2,
    LOOKUP = 3'd3,
    WAIT   = 3'd4,
    DONE   = 3'd5
  } resp_state_e;

  // True when both coordinates fall inside the N x N board.
  function automatic logic coord_ok(input logic [COORD_W-1:0] r,
                                    input logic [COORD_W-1:0] c);
    return (int'(r) < N) && (int'(c) < N);
  endfunction

  // Row-major cell index into a shot map.
  function automatic logic [IDX_W-1:0] cell_idx(input logic [COORD_W-1:0] r,
                                                input logic [COORD_W-1:0] c);
    return IDX_W'(int'(r) * N + int'(c));
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, taps 16,14,13,11, shifting left.
//   clk, rst : clock, asynchronous active-low reset (loads seed)
//   en       : advance one step
//   seed     : reset value (must be non-zero)
//   value    : current register contents
module lfsr16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] seed,
  output logic [15:0] value
);

  logic [15:0] lfsr_r;
  logic        fb_s;

  assign fb_s  = lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10];
  assign value = lfsr_r;

  // Shift register; seed is a constant at the only instantiation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_r <= seed;
    end else if (en) begin
      lfsr_r <= {lfsr_r[14:0], fb_s};
    end else begin
      lfsr_r <= lfsr_r;
    end
  end

endmodule

// File: rtl/attack_responder.sv
// Attack/check phase executor for the game-flow FSM.
// Runs the turn timer, takes a manual or random target, queries the ship
// map, records the shot and updates turno / gameover before the check.
//   en_attack_p1/p2, en_attack_random, en_check : phase requests
//   select, row_in, col_in                       : player aim
//   board_req/sel/row/col, board_rsp             : ship-map read port
//   end_attack_p1/p2, timeout, turno, gameover,
//   winner, hit, hit_valid                       : status back to the FSM
module attack_responder
  import game_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 750000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_attack_p1,
  input  logic               en_attack_p2,
  input  logic               en_attack_random,
  input  logic               en_check,
  input  logic               select,
  input  logic [COORD_W-1:0] row_in,
  input  logic [COORD_W-1:0] col_in,
  input  logic               board_rsp,
  output logic               board_req,
  output logic               board_sel,
  output logic [COORD_W-1:0] board_row,
  output logic [COORD_W-1:0] board_col,
  output logic               end_attack_p1,
  output logic               end_attack_p2,
  output logic               timeout,
  output logic               turno,
  output logic               gameover,
  output logic               winner,
  output logic               hit,
  output logic               hit_valid
);

  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);
  localparam int CNT_W   = $clog2(SHIP_CELLS + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(SHIP_CELLS - 1);

  resp_state_e state_r, state_n_s;

  logic               en_p1_s, en_p2_s, en_rand_s, en_check_s;
  logic               busy_r, phase_p1_r, shooter_r, manual_r;
  logic [TIMER_W-1:0] timer_r;
  logic               timeout_r, counting_s, expiry_s;
  logic [CELLS-1:0]   shots_p1_r, shots_p2_r, cur_shots_s;
  logic [CNT_W-1:0]   cnt_p1_r, cnt_p2_r, cur_cnt_s;
  logic [15:0]        lfsr_s;
  logic               lfsr_unused_s;
  logic [COORD_W-1:0] cand_row_s, cand_col_s;
  logic               cand_ok_s, accept_s, win_s;
  logic [IDX_W-1:0]   wait_idx_s;

  logic               board_req_r, board_sel_r;
  logic [COORD_W-1:0] board_row_r, board_col_r;
  logic               end_p1_r, end_p2_r, turno_r, gameover_r, winner_r;
  logic               hit_r, hit_valid_r;

  // Once the game is over every phase request is dead.
  assign en_p1_s    = en_attack_p1     & ~gameover_r;
  assign en_p2_s    = en_attack_p2     & ~gameover_r;
  assign en_rand_s  = en_attack_random & ~gameover_r;
  assign en_check_s = en_check         & ~gameover_r;

  lfsr16 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .en    (1'b1),
    .seed  (16'hACE1),
    .value (lfsr_s)
  );

  assign lfsr_unused_s = ^lfsr_s[15:6];

  assign counting_s = busy_r && (state_r == AIM) && !timeout_r;
  assign expiry_s   = counting_s && (timer_r == TIMER_LAST);
  assign wait_idx_s = cell_idx(board_row_r, board_col_r);
  assign win_s      = board_rsp && (cur_cnt_s == CNT_LAST);

  // Shot map and hit counter of the current shooter.
  always_comb begin
    cur_shots_s = shots_p1_r;
    cur_cnt_s   = cnt_p1_r;
    if (shooter_r == PLAYER2) begin
      cur_shots_s = shots_p2_r;
      cur_cnt_s   = cnt_p2_r;
    end else begin
      cur_shots_s = shots_p1_r;
      cur_cnt_s   = cnt_p1_r;
    end
  end

  // Candidate target: LFSR bits while randomizing, player input otherwise.
  always_comb begin
    cand_row_s = row_in;
    cand_col_s = col_in;
    if (state_r == RAND) begin
      cand_row_s = lfsr_s[2:0];
      cand_col_s = lfsr_s[5:3];
    end else begin
      cand_row_s = row_in;
      cand_col_s = col_in;
    end
    cand_ok_s = coord_ok(cand_row_s, cand_col_s) &&
                !cur_shots_s[cell_idx(cand_row_s, cand_col_s)];
  end

  // Next-state logic; a select in the expiry cycle loses to the timeout.
  always_comb begin
    state_n_s = state_r;
    accept_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (en_rand_s) begin
          state_n_s = RAND;
        end else if (busy_r) begin
          state_n_s = AIM;
        end else begin
          state_n_s = IDLE;
        end
      end
      AIM: begin
        if (en_rand_s) begin
          state_n_s = RAND;
        end else if (select && cand_ok_s && !timeout_r && !expiry_s) begin
          state_n_s = LOOKUP;
          accept_s  = 1'b1;
        end else begin
          state_n_s = AIM;
        end
      end
      RAND: begin
        if (cand_ok_s) begin
          state_n_s = LOOKUP;
          accept_s  = 1'b1;
        end else begin
          state_n_s = RAND;
        end
      end
      LOOKUP:  state_n_s = WAIT;
      WAIT:    state_n_s = DONE;
      DONE: begin
        if (en_check_s) begin
          state_n_s = IDLE;
        end else begin
          state_n_s = DONE;
        end
      end
      default: state_n_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n_s;
    end
  end

  // Sticky attack phase: the FSM only pulses its enables every other cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_r     <= 1'b0;
      phase_p1_r <= 1'b0;
    end else if (en_check_s || en_rand_s) begin
      busy_r <= 1'b0;
    end else if (!busy_r && (en_p1_s || en_p2_s)) begin
      busy_r     <= 1'b1;
      phase_p1_r <= en_p1_s;
    end
  end

  // Turn timer; timeout holds until the random attack is requested.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_r   <= '0;
      timeout_r <= 1'b0;
    end else begin
      if (en_check_s) begin
        timer_r <= '0;
      end else if (counting_s && !expiry_s) begin
        timer_r <= timer_r + TIMER_W'(1);
      end
      if (en_rand_s) begin
        timeout_r <= 1'b0;
      end else if (expiry_s) begin
        timeout_r <= 1'b1;
      end
    end
  end

  // Query, shot recording and status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shooter_r   <= PLAYER1;
      manual_r    <= 1'b0;
      shots_p1_r  <= '0;
      shots_p2_r  <= '0;
      cnt_p1_r    <= '0;
      cnt_p2_r    <= '0;
      board_req_r <= 1'b0;
      board_sel_r <= 1'b0;
      board_row_r <= '0;
      board_col_r <= '0;
      end_p1_r    <= 1'b0;
      end_p2_r    <= 1'b0;
      turno_r     <= 1'b1;
      gameover_r  <= 1'b0;
      winner_r    <= 1'b0;
      hit_r       <= 1'b0;
      hit_valid_r <= 1'b0;
    end else begin
      hit_valid_r <= 1'b0;
      board_req_r <= accept_s;
      if (accept_s) begin
        board_sel_r <= ~shooter_r;
        board_row_r <= cand_row_s;
        board_col_r <= cand_col_s;
      end
      // Shooter is fixed on phase entry: enable for manual, turno for random.
      if ((state_r == IDLE) && (state_n_s == AIM)) begin
        shooter_r <= phase_p1_r ? PLAYER1 : PLAYER2;
        manual_r  <= 1'b1;
      end else if ((state_r != RAND) && (state_n_s == RAND)) begin
        shooter_r <= turno_r ? PLAYER1 : PLAYER2;
        manual_r  <= 1'b0;
      end
      if (state_r == WAIT) begin
        hit_r       <= board_rsp;
        hit_valid_r <= 1'b1;
        if (shooter_r == PLAYER1) begin
          shots_p1_r[wait_idx_s] <= 1'b1;
          if (board_rsp) begin
            cnt_p1_r <= cnt_p1_r + CNT_W'(1);
          end
        end else begin
          shots_p2_r[wait_idx_s] <= 1'b1;
          if (board_rsp) begin
            cnt_p2_r <= cnt_p2_r + CNT_W'(1);
          end
        end
        if (win_s) begin
          gameover_r <= 1'b1;
          winner_r   <= shooter_r;
        end else begin
          turno_r <= ~turno_r;
        end
        if (manual_r) begin
          if (shooter_r == PLAYER1) begin
            end_p1_r <= 1'b1;
          end else begin
            end_p2_r <= 1'b1;
          end
        end
      end
      if ((state_r == DONE) && en_check_s) begin
        end_p1_r <= 1'b0;
        end_p2_r <= 1'b0;
      end
    end
  end

  assign board_req     = board_req_r;
  assign board_sel     = board_sel_r;
  assign board_row     = board_row_r;
  assign board_col     = board_col_r;
  assign end_attack_p1 = end_p1_r;
  assign end_attack_p2 = end_p2_r;
  assign timeout       = timeout_r;
  assign turno         = turno_r;
  assign gameover      = gameover_r;
  assign winner        = winner_r;
  assign hit           = hit_r;
  assign hit_valid     = hit_valid_r;

endmodule

// File: tb/tb_attack_responder.sv
// Self-checking bench for attack_responder with a short turn timer.
// A reference model of both boards, shot sets, hit counts, turno and
// gameover predicts every status output.
module tb_attack_responder;
  import game_pkg::*;

  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en_attack_p1 = 1'b0, en_attack_p2 = 1'b0;
  logic       en_attack_random = 1'b0, en_check = 1'b0, select = 1'b0;
  logic [2:0] row_in = 3'd0, col_in = 3'd0;
  logic       board_rsp = 1'b0;
  logic       board_req, board_sel, end_attack_p1, end_attack_p2;
  logic       timeout, turno, gameover, winner, hit, hit_valid;
  logic [2:0] board_row, board_col;

  int total = 0;
  int bad   = 0;

  // Reference model (shooter index 0 = player 1, 1 = player 2).
  bit ship   [2][25];
  bit shot_m [2][25];
  int cnt_m  [2];
  bit turno_m, go_m, win_m;
  int p1_list[$];

  attack_responder #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .en_attack_p1(en_attack_p1), .en_attack_p2(en_attack_p2),
    .en_attack_random(en_attack_random), .en_check(en_check),
    .select(select), .row_in(row_in), .col_in(col_in),
    .board_rsp(board_rsp), .board_req(board_req), .board_sel(board_sel),
    .board_row(board_row), .board_col(board_col),
    .end_attack_p1(end_attack_p1), .end_attack_p2(end_attack_p2),
    .timeout(timeout), .turno(turno), .gameover(gameover),
    .winner(winner), .hit(hit), .hit_valid(hit_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      cnt_m[b] = 0;
      for (int k = 0; k < 25; k++) shot_m[b][k] = 1'b0;
    end
    turno_m = 1'b1;
    go_m    = 1'b0;
    win_m   = 1'b0;
  endtask

  task automatic check_reset_vals();
    chk("rst_req",   32'(board_req), 32'd0);
    chk("rst_end1",  32'(end_attack_p1), 32'd0);
    chk("rst_end2",  32'(end_attack_p2), 32'd0);
    chk("rst_tmo",   32'(timeout), 32'd0);
    chk("rst_turno", 32'(turno), 32'd1);
    chk("rst_go",    32'(gameover), 32'd0);
    chk("rst_win",   32'(winner), 32'd0);
    chk("rst_hit",   32'(hit), 32'd0);
    chk("rst_hv",    32'(hit_valid), 32'd0);
  endtask

  function automatic int pick_cell(input int brd, input int shooter, input bit want_ship);
    int k;
    for (int t = 0; t < 4000; t++) begin
      k = int'($urandom_range(0, 24));
      if (ship[brd][k] == want_ship && !shot_m[shooter][k]) return k;
    end
    return 0;
  endfunction

  // Enable pulses every other cycle, as the game FSM does.
  task automatic start_turn(input bit s);
    for (int i = 0; i < 4; i++) begin
      en_attack_p1 = (s == 1'b0) && (i % 2 == 0);
      en_attack_p2 = (s == 1'b1) && (i % 2 == 0);
      tick();
    end
    en_attack_p1 = 1'b0;
    en_attack_p2 = 1'b0;
  endtask

  task automatic end_turn();
    en_check = 1'b1;
    tick();
    en_check = 1'b0;
    chk("chk_end1", 32'(end_attack_p1), 32'd0);
    chk("chk_end2", 32'(end_attack_p2), 32'd0);
    tick();
  endtask

  task automatic try_reject(input int r, input int c, input string tag);
    bit seen;
    seen = 1'b0;
    row_in = 3'(r); col_in = 3'(c); select = 1'b1;
    tick();
    select = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (board_req !== 1'b0) seen = 1'b1;
      tick();
    end
    chk({tag, "_req"}, 32'(seen), 32'd0);
    chk({tag, "_end"}, 32'(end_attack_p1 | end_attack_p2), 32'd0);
  endtask

  task automatic wait_query();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (board_req === 1'b1) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("query_seen", 32'(found), 32'd1);
  endtask

  // Answer the pending query from the model boards and check the result.
  task automatic respond(input bit s, input bit manual);
    int r, c, idx;
    bit h;
    r = int'(board_row);
    c = int'(board_col);
    chk("query_sel", 32'(board_sel), 32'(!s));
    chk("query_range", 32'(r < N && c < N), 32'd1);
    idx = (r < N && c < N) ? r * N + c : 0;
    chk("query_unshot", 32'(shot_m[s][idx]), 32'd0);
    h = ship[!s][idx];
    board_rsp = h;
    tick();
    chk("req_pulse", 32'(board_req), 32'd0);
    tick();
    shot_m[s][idx] = 1'b1;
    if (h) cnt_m[s]++;
    if (cnt_m[s] == SHIP_CELLS) begin
      go_m  = 1'b1;
      win_m = s;
    end else begin
      turno_m = !turno_m;
    end
    chk("hit_valid", 32'(hit_valid), 32'd1);
    chk("hit", 32'(hit), 32'(h));
    chk("turno", 32'(turno), 32'(turno_m));
    chk("gameover", 32'(gameover), 32'(go_m));
    chk("winner", 32'(winner), 32'(win_m));
    chk("end1", 32'(end_attack_p1), 32'(manual && !s));
    chk("end2", 32'(end_attack_p2), 32'(manual && s));
    board_rsp = 1'b0;
    tick();
    chk("hv_pulse", 32'(hit_valid), 32'd0);
  endtask

  task automatic shoot_manual(input bit s, input int r, input int c);
    row_in = 3'(r); col_in = 3'(c); select = 1'b1;
    tick();
    select = 1'b0;
    wait_query();
    chk("query_row", 32'(board_row), 32'(r));
    chk("query_col", 32'(board_col), 32'(c));
    respond(s, 1'b1);
  endtask

  initial begin
    int k, nxt, misses;
    bit seen;

    // Boards: player 2's board always carries ships at (2,3) and (0,0).
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 25; i++) ship[b][i] = 1'b0;
    ship[1][13] = 1'b1; p1_list.push_back(13);
    ship[1][0]  = 1'b1; p1_list.push_back(0);
    while (p1_list.size() < SHIP_CELLS) begin
      k = int'($urandom_range(0, 24));
      if (!ship[1][k]) begin
        ship[1][k] = 1'b1;
        p1_list.push_back(k);
      end
    end
    k = 0;
    for (int n = 0; n < 2000 && k < SHIP_CELLS; n++) begin
      nxt = int'($urandom_range(0, 24));
      if (!ship[0][nxt]) begin
        ship[0][nxt] = 1'b1;
        k++;
      end
    end
    model_reset();

    #2 rst = 1'b0;
    #10;
    check_reset_vals();
    chk("rst_lfsr", 32'(dut.lfsr_s), 32'h0000ACE1);
    tick();
    rst = 1'b1;
    tick();

    // Player 1 hits (2,3).
    start_turn(1'b0);
    shoot_manual(1'b0, 2, 3);
    end_turn();

    // Player 2 lets the timer expire, then the random attack fires.
    start_turn(1'b1);
    repeat (10) tick();
    chk("tmo_early", 32'(timeout), 32'd0);
    repeat (12) tick();
    chk("tmo_set", 32'(timeout), 32'd1);
    try_reject(4, 4, "tmo_select");
    chk("tmo_hold", 32'(timeout), 32'd1);
    en_attack_random = 1'b1;
    tick();
    en_attack_random = 1'b0;
    chk("tmo_clear", 32'(timeout), 32'd0);
    wait_query();
    respond(1'b1, 1'b0);
    end_turn();

    // Player 1: repeated cell and out-of-range cell ignored, (0,0) taken.
    start_turn(1'b0);
    try_reject(2, 3, "dup_cell");
    try_reject(6, 1, "out_range");
    shoot_manual(1'b0, 0, 0);
    end_turn();

    // Alternate turns until player 1 sinks all six ship cells.
    nxt = 2;
    misses = 0;
    for (int t = 0; t < 12 && !go_m; t++) begin
      k = pick_cell(0, 1, 1'b0);
      start_turn(1'b1);
      shoot_manual(1'b1, k / N, k % N);
      end_turn();
      if (misses < 3 && $urandom_range(0, 2) == 0) begin
        k = pick_cell(1, 0, 1'b0);
        misses++;
      end else begin
        k = p1_list[nxt];
        nxt++;
      end
      start_turn(1'b0);
      shoot_manual(1'b0, k / N, k % N);
      if (!go_m) end_turn();
    end
    chk("final_go", 32'(gameover), 32'd1);

    // Everything after gameover is ignored.
    seen = 1'b0;
    en_check = 1'b1; tick(); en_check = 1'b0;
    seen |= board_req | hit_valid;
    for (int i = 0; i < 4; i++) begin
      en_attack_p2 = (i % 2 == 0);
      tick();
      seen |= board_req | hit_valid;
    end
    en_attack_p2 = 1'b0;
    row_in = 3'd4; col_in = 3'd3; select = 1'b1; tick(); select = 1'b0;
    en_attack_random = 1'b1; tick(); en_attack_random = 1'b0;
    for (int i = 0; i < 8; i++) begin
      seen |= board_req | hit_valid;
      tick();
    end
    chk("post_go_quiet", 32'(seen), 32'd0);
    chk("post_go_end1", 32'(end_attack_p1), 32'd1);
    chk("post_go_go", 32'(gameover), 32'd1);
    chk("post_go_win", 32'(winner), 32'd0);
    chk("post_go_turno", 32'(turno), 32'(turno_m));

    // Reset in the WAIT cycle discards the shot.
    rst = 1'b0; tick(); rst = 1'b1; tick();
    model_reset();
    start_turn(1'b0);
    row_in = 3'd2; col_in = 3'd3; select = 1'b1; tick(); select = 1'b0;
    wait_query();
    board_rsp = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_reset_vals();
    tick();
    rst = 1'b1;
    board_rsp = 1'b0;
    tick();
    start_turn(1'b0);
    shoot_manual(1'b0, 2, 3);
    end_turn();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
